// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with hex decode, LZ suppression,
// PWM brightness and frame-synchronous shadow/active data update.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_LOG2  = 17,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } disp_t;

  disp_t                shadow;
  disp_t                active;
  disp_t                load_dat;
  logic                 pending;
  logic [SLOT_LOG2-1:0] tick;
  logic [IDX_W-1:0]     idx;
  logic                 slot_end;
  logic                 frame_end;

  assign load_dat  = '{value: value, dp: dp_in, blank: blank_in};
  assign slot_end  = &tick;
  assign frame_end = slot_end && (idx == LAST_IDX);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tick <= '0;
      idx  <= '0;
    end else begin
      tick <= tick + 1'b1;
      if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
    end
  end

  // A load coinciding with the frame wrap lands in shadow while active takes the
  // old shadow, so pending must stay set for the following frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= load_dat;
      if (frame_end && pending) active <= shadow;
      if (load) pending <= 1'b1;
      else if (frame_end) pending <= 1'b0;
    end
  end

  logic [NUM_DIGITS-1:0] supp;
  logic                  above_dark;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_supp;
  logic [BRIGHT_W-1:0]   phase;
  logic                  lit;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  fs_nxt;

  // Suppression ripples down from the most significant digit.
  always_comb begin
    supp       = '0;
    above_dark = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      supp[i]    = lz_en && (active.value[4*i +: 4] == 4'h0) && !active.dp[i] && above_dark;
      above_dark = above_dark && (supp[i] || active.blank[i]);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_supp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = active.value[4*i +: 4];
        cur_dp    = active.dp[i];
        cur_blank = active.blank[i];
        cur_supp  = supp[i];
      end
    end
    phase   = tick[SLOT_LOG2-1 -: BRIGHT_W];
    lit     = !cur_blank && !cur_supp && (phase < bright);
    seg_nxt = lit ? hex7(cur_nib) : 7'h7F;
    dp_nxt  = lit ? ~cur_dp : 1'b1;
    an_nxt  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == IDX_W'(i))) an_nxt[i] = 1'b0;
    end
    fs_nxt  = (idx == '0) && (tick == '0);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      an          <= an_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl at 4 digits, 16-cycle slots, 2-bit brightness.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [1:0]  bright;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int multi_low = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .SLOT_LOG2(4), .BRIGHT_W(2)) dut (
    .clk(clk), .clr_n(clr_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .bright(bright), .seg(seg), .dp(dp),
    .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Edges since reset release; sampled on the falling edge.
  always @(posedge clk) begin
    if (!clr_n) cyc = 0;
    else cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (clr_n && ($countones(~an) > 1)) multi_low++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    int g = 0;
    while (cyc < t && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != t) begin
      errors++;
      $display("FAIL wait_cyc: got %0d expected %0d", cyc, t);
    end
  endtask

  initial begin
    int scan_bad, seg_bad, fs_cnt, dark_bad;
    int low [4];
    logic [3:0] exp_an;
    bit lit;

    clr_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
    lz_en = 1'b0; bright = 2'd3;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    clr_n = 1'b1;

    // Plain scan of the reset data: 12 lit cycles per 16-cycle slot
    scan_bad = 0; seg_bad = 0; fs_cnt = 0;
    for (int i = 0; i < 4; i++) low[i] = 0;
    for (int k = 1; k <= 128; k++) begin
      wait_cyc(k);
      lit    = ((k - 1) % 16) < 12;
      exp_an = lit ? ~(4'b0001 << (((k - 1) / 16) % 4)) : 4'hF;
      if (an !== exp_an) scan_bad++;
      if (lit && seg !== 7'b1000000) seg_bad++;
      if (frame_start) fs_cnt++;
      if (k <= 64) for (int i = 0; i < 4; i++) if (!an[i]) low[i]++;
      if (k == 1) check("fs_first", frame_start, 1'b1);
      if (k == 65) check("fs_second", frame_start, 1'b1);
      if (k == 66) check("fs_pulse_len", frame_start, 1'b0);
    end
    check("scan_an", scan_bad, 0);
    check("scan_seg", seg_bad, 0);
    for (int i = 0; i < 4; i++) check($sformatf("scan_low%0d", i), low[i], 12);
    check("fs_count", fs_cnt, 2);

    // Mid-frame load only appears after the wrap
    wait_cyc(148);
    value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    wait_cyc(149);
    load = 1'b0; dp_in = '0;
    wait_cyc(180);
    check("sync_old_an", an, 4'b0111);
    check("sync_old_seg", seg, 7'b1000000);
    wait_cyc(193);
    check("sync_d0_an", an, 4'b1110);
    check("sync_d0_seg", seg, 7'b0001110);
    check("sync_d0_dp", dp, 1'b1);
    wait_cyc(209);
    check("sync_d1_seg", seg, 7'b0001000);
    wait_cyc(225);
    check("sync_d2_an", an, 4'b1011);
    check("sync_d2_seg", seg, 7'b0100100);
    check("sync_d2_dp", dp, 1'b0);
    wait_cyc(241);
    check("sync_d3_seg", seg, 7'b1111001);
    check("sync_d3_dp", dp, 1'b1);

    // Load in the exact wrap cycle
    wait_cyc(255);
    value = 16'h0005; load = 1'b1;
    wait_cyc(256);
    load = 1'b0;
    check("coll_pending_set", dut.pending, 1'b1);
    wait_cyc(257);
    check("coll_old_an", an, 4'b1110);
    check("coll_old_seg", seg, 7'b0001110);
    wait_cyc(321);
    check("coll_new_seg", seg, 7'b0010010);
    check("coll_pending_clr", dut.pending, 1'b0);
    wait_cyc(337);
    check("coll_d1_an", an, 4'b1101);
    check("coll_d1_seg", seg, 7'b1000000);

    // Leading-zero suppression
    wait_cyc(340);
    lz_en = 1'b1; value = 16'h0050; load = 1'b1;
    wait_cyc(341);
    load = 1'b0;
    wait_cyc(385);
    check("lz50_d0_an", an, 4'b1110);
    check("lz50_d0_seg", seg, 7'b1000000);
    wait_cyc(401);
    check("lz50_d1_an", an, 4'b1101);
    check("lz50_d1_seg", seg, 7'b0010010);
    wait_cyc(417);
    check("lz50_d2_an", an, 4'hF);
    wait_cyc(433);
    check("lz50_d3_an", an, 4'hF);
    wait_cyc(450);
    value = 16'h0000; load = 1'b1;
    wait_cyc(451);
    load = 1'b0;
    wait_cyc(513);
    check("lz0_d0_an", an, 4'b1110);
    check("lz0_d0_seg", seg, 7'b1000000);
    wait_cyc(529);
    check("lz0_d1_an", an, 4'hF);
    wait_cyc(545);
    check("lz0_d2_an", an, 4'hF);
    wait_cyc(561);
    check("lz0_d3_an", an, 4'hF);
    lz_en = 1'b0;
    wait_cyc(562);
    check("lz_off_live_an", an, 4'b0111);
    check("lz_off_live_seg", seg, 7'b1000000);

    // Brightness 0 keeps everything dark for a whole frame
    wait_cyc(570);
    bright = 2'd0;
    dark_bad = 0;
    for (int k = 571; k <= 634; k++) begin
      wait_cyc(k);
      if (an !== 4'hF) dark_bad++;
    end
    check("bright0_dark", dark_bad, 0);

    // Brightness 1: a quarter of each slot
    wait_cyc(640);
    bright = 2'd1;
    for (int i = 0; i < 4; i++) low[i] = 0;
    for (int k = 641; k <= 704; k++) begin
      wait_cyc(k);
      for (int i = 0; i < 4; i++) if (!an[i]) low[i]++;
    end
    for (int i = 0; i < 4; i++) check($sformatf("bright1_low%0d", i), low[i], 4);

    // Blanking digit 1
    wait_cyc(705);
    value = 16'h0000; blank_in = 4'b0010; load = 1'b1; bright = 2'd3;
    wait_cyc(706);
    load = 1'b0; blank_in = '0;
    for (int i = 0; i < 4; i++) low[i] = 0;
    for (int k = 769; k <= 832; k++) begin
      wait_cyc(k);
      for (int i = 0; i < 4; i++) if (!an[i]) low[i]++;
    end
    check("blank_d1_low", low[1], 0);
    check("blank_d0_low", low[0], 12);
    check("blank_d2_low", low[2], 12);

    // Asynchronous reset in slot 2
    wait_cyc(868);
    check("mid_pre_an", an, 4'b1011);
    clr_n = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_dp", dp, 1'b1);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    wait_cyc(1);
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 7'b1000000);
    check("post_rst_fs", frame_start, 1'b1);

    check("one_anode_max", multi_low, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
